// File: rtl/thermal_sched_pkg.sv
// rtl/thermal_sched_pkg.sv - shared types and constants for the thermal task scheduler
package thermal_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SELECT    = 2'd1,
    DISPATCH  = 2'd2,
    WAIT_COOL = 2'd3
  } sched_state_t;

  localparam int NUM_CORES = 3;
  localparam int TEMP_W    = 8;
  localparam int DATA_W    = 16;

  localparam logic [1:0] CORE_NONE = 2'b11;

  // CORE_NONE shifts the single bit out, giving an empty strobe
  function automatic logic [NUM_CORES-1:0] core_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/coolest_core_picker.sv
// rtl/coolest_core_picker.sv - combinational minimum-temperature search over an eligibility mask
module coolest_core_picker
  import thermal_sched_pkg::*;
(
  input  logic [TEMP_W-1:0]    temp0,
  input  logic [TEMP_W-1:0]    temp1,
  input  logic [TEMP_W-1:0]    temp2,
  input  logic [NUM_CORES-1:0] eligible,
  output logic [1:0]           idx,
  output logic                 found
);

  logic [TEMP_W-1:0] temps [NUM_CORES];
  logic [TEMP_W-1:0] best;

  assign temps[0] = temp0;
  assign temps[1] = temp1;
  assign temps[2] = temp2;

  // strict less-than keeps the lowest index on ties
  always_comb begin
    idx   = CORE_NONE;
    found = 1'b0;
    best  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (eligible[i] && (!found || temps[i] < best)) begin
        found = 1'b1;
        best  = temps[i];
        idx   = 2'(i);
      end
    end
  end

endmodule

// File: rtl/thermal_task_scheduler.sv
// rtl/thermal_task_scheduler.sv - dispatches handshaked tasks to the coolest eligible core
module thermal_task_scheduler
  import thermal_sched_pkg::*;
#(
  parameter logic [TEMP_W-1:0] THRESHOLD   = 8'd75,
  parameter logic [TEMP_W-1:0] HYST        = 8'd5,
  parameter int                ACK_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 task_valid,
  input  logic [DATA_W-1:0]    task_data,
  output logic                 task_ready,
  input  logic [TEMP_W-1:0]    temp_core0,
  input  logic [TEMP_W-1:0]    temp_core1,
  input  logic [TEMP_W-1:0]    temp_core2,
  input  logic [NUM_CORES-1:0] core_ack,
  output logic [DATA_W-1:0]    data_out,
  output logic [1:0]           core_select,
  output logic [NUM_CORES-1:0] core_valid,
  output logic                 all_hot,
  output logic [NUM_CORES-1:0] core_fault,
  output logic [15:0]          dispatch_count
);

  localparam logic [7:0]        TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [TEMP_W-1:0] RESUME_TEMP  = THRESHOLD - HYST;

  sched_state_t state, state_next;
  logic [7:0]   timeout_cnt;

  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] cool_mask;
  logic [1:0]           pick_idx;
  logic                 pick_found;
  logic [1:0]           cool_idx;
  logic                 cool_found;
  logic                 ack_hit;
  logic                 timed_out;
  logic                 resume;

  assign eligible  = {temp_core2 < THRESHOLD, temp_core1 < THRESHOLD, temp_core0 < THRESHOLD}
                     & ~core_fault;
  assign cool_mask = {temp_core2 <= RESUME_TEMP, temp_core1 <= RESUME_TEMP, temp_core0 <= RESUME_TEMP}
                     & ~core_fault;

  coolest_core_picker u_pick_threshold (
    .temp0    (temp_core0),
    .temp1    (temp_core1),
    .temp2    (temp_core2),
    .eligible (eligible),
    .idx      (pick_idx),
    .found    (pick_found)
  );

  coolest_core_picker u_pick_hysteresis (
    .temp0    (temp_core0),
    .temp1    (temp_core1),
    .temp2    (temp_core2),
    .eligible (cool_mask),
    .idx      (cool_idx),
    .found    (cool_found)
  );

  // core_valid is one-hot on the selected core, so this masks out stray acks
  assign ack_hit   = |(core_ack & core_valid);
  assign timed_out = (timeout_cnt == TIMEOUT_LAST);
  assign resume    = cool_found && (cool_idx != CORE_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (task_valid) state_next = SELECT;
      SELECT:    state_next = pick_found ? DISPATCH : WAIT_COOL;
      DISPATCH: begin
        if (ack_hit) begin
          state_next = IDLE;
        end else if (timed_out) begin
          state_next = SELECT;
        end
      end
      WAIT_COOL: if (resume) state_next = SELECT;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    task_ready = (state == IDLE);
    all_hot    = (state == WAIT_COOL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out       <= '0;
      core_select    <= CORE_NONE;
      core_valid     <= '0;
      core_fault     <= '0;
      dispatch_count <= '0;
      timeout_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (task_valid) data_out <= task_data;
        end
        SELECT: begin
          timeout_cnt <= '0;
          if (pick_found) begin
            core_select <= pick_idx;
            core_valid  <= core_onehot(pick_idx);
          end
        end
        DISPATCH: begin
          if (ack_hit) begin
            core_valid     <= '0;
            core_select    <= CORE_NONE;
            dispatch_count <= dispatch_count + 16'd1;
          end else if (timed_out) begin
            core_fault  <= core_fault | core_valid;
            core_valid  <= '0;
            core_select <= CORE_NONE;
          end else begin
            timeout_cnt <= timeout_cnt + 8'd1;
          end
        end
        WAIT_COOL: begin
          core_valid  <= '0;
          core_select <= CORE_NONE;
        end
        default: ;
      endcase
    end
  end

endmodule
